// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle: pipeline hazard inputs and stall/flush controls.
// The slave modport is the controller side, the master modport is the pipeline side.
interface hazard_stall_ctrl_if;
    logic [4:0] IF_ID_RsAddr_i;
    logic [4:0] IF_ID_RtAddr_i;
    logic       ID_EX_MemRead_i;
    logic [4:0] ID_EX_RtAddr_i;
    logic       ID_EX_MulDiv_i;
    logic       ID_EX_IsDiv_i;
    logic       EX_BranchTaken_i;
    logic       PC_Write_o;
    logic       IF_ID_Write_o;
    logic       ID_EX_Write_o;
    logic       IF_ID_Flush_o;
    logic       ID_EX_Flush_o;
    logic       EX_MEM_Flush_o;
    logic       MulDiv_Busy_o;
    logic       MulDiv_Done_o;

    modport slave (
        input  IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_EX_MemRead_i, ID_EX_RtAddr_i,
        input  ID_EX_MulDiv_i, ID_EX_IsDiv_i, EX_BranchTaken_i,
        output PC_Write_o, IF_ID_Write_o, ID_EX_Write_o,
        output IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o,
        output MulDiv_Busy_o, MulDiv_Done_o
    );

    modport master (
        output IF_ID_RsAddr_i, IF_ID_RtAddr_i, ID_EX_MemRead_i, ID_EX_RtAddr_i,
        output ID_EX_MulDiv_i, ID_EX_IsDiv_i, EX_BranchTaken_i,
        input  PC_Write_o, IF_ID_Write_o, ID_EX_Write_o,
        input  IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o,
        input  MulDiv_Busy_o, MulDiv_Done_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush, MUL/DIV EX occupancy.
// Define HAZARD_STALL_STATS_EN to add saturating load-use / hold / flush event counters.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_stall_ctrl_if.slave  hz
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0]         Stat_LoadUse_o,
    output logic [31:0]         Stat_MulDivHold_o,
    output logic [31:0]         Stat_Flush_o
`endif
);

    typedef enum logic {StIdle, StMdBusy} state_e;

    state_e     stateQ, stateD;
    logic [4:0] cntQ, cntD;
    logic [5:0] lat;
    logic       startOp;
    logic       hold;
    logic       luse;
    logic       branch;
    logic       luseApplied;
    logic       flushApplied;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        lat     = hz.ID_EX_IsDiv_i ? 6'(DIV_LAT) : 6'(MUL_LAT);
        startOp = (stateQ == StIdle) && hz.ID_EX_MulDiv_i && (lat >= 6'd2);
        hold    = !rst_i && (startOp || ((stateQ == StMdBusy) && (cntQ != 5'd0)));
        luse    = hz.ID_EX_MemRead_i && (hz.ID_EX_RtAddr_i != 5'd0) &&
                  ((hz.ID_EX_RtAddr_i == hz.IF_ID_RsAddr_i) ||
                   (hz.ID_EX_RtAddr_i == hz.IF_ID_RtAddr_i));
        branch  = hz.EX_BranchTaken_i;
        flushApplied = !rst_i && !hold && branch;
        luseApplied  = !rst_i && !hold && !branch && luse;

        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (startOp) begin
                    cntD   = 5'(lat - 6'd2);
                    stateD = StMdBusy;
                end
            end
            StMdBusy: begin
                // A MUL/DIV still in EX on the Done cycle is not a new start.
                if (cntQ != 5'd0) cntD = cntQ - 5'd1;
                else              stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        hz.PC_Write_o     = 1'b1;
        hz.IF_ID_Write_o  = 1'b1;
        hz.ID_EX_Write_o  = 1'b1;
        hz.IF_ID_Flush_o  = 1'b0;
        hz.ID_EX_Flush_o  = 1'b0;
        hz.EX_MEM_Flush_o = 1'b0;
        hz.MulDiv_Busy_o  = 1'b0;
        hz.MulDiv_Done_o  = 1'b0;
        if (!rst_i) begin
            hz.MulDiv_Busy_o = (stateQ == StMdBusy);
            hz.MulDiv_Done_o = ((stateQ == StIdle) && hz.ID_EX_MulDiv_i && (lat == 6'd1)) ||
                               ((stateQ == StMdBusy) && (cntQ == 5'd0));
            if (hold) begin
                hz.PC_Write_o     = 1'b0;
                hz.IF_ID_Write_o  = 1'b0;
                hz.ID_EX_Write_o  = 1'b0;
                hz.EX_MEM_Flush_o = 1'b1;
            end else if (branch) begin
                hz.IF_ID_Flush_o = 1'b1;
                hz.ID_EX_Flush_o = 1'b1;
            end else if (luse) begin
                hz.PC_Write_o    = 1'b0;
                hz.IF_ID_Write_o = 1'b0;
                hz.ID_EX_Flush_o = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] statLuseQ, statHoldQ, statFlushQ;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            statLuseQ  <= '0;
            statHoldQ  <= '0;
            statFlushQ <= '0;
        end else begin
            if (luseApplied && (statLuseQ != '1))   statLuseQ  <= statLuseQ + 32'd1;
            if (hold && (statHoldQ != '1))          statHoldQ  <= statHoldQ + 32'd1;
            if (flushApplied && (statFlushQ != '1)) statFlushQ <= statFlushQ + 32'd1;
        end
    end

    assign Stat_LoadUse_o    = statLuseQ;
    assign Stat_MulDivHold_o = statHoldQ;
    assign Stat_Flush_o      = statFlushQ;
`else
    logic unusedStats;
    assign unusedStats = luseApplied ^ flushApplied;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector tables plus MUL/DIV and reset sequences, scoreboarded.
module tb_hazard_stall_ctrl;

    localparam logic [7:0] Norm   = 8'b111_000_0_0;
    localparam logic [7:0] Luse   = 8'b001_010_0_0;
    localparam logic [7:0] Br     = 8'b111_110_0_0;
    localparam logic [7:0] Hold0  = 8'b000_001_0_0;
    localparam logic [7:0] HoldB  = 8'b000_001_1_0;
    localparam logic [7:0] DoneB  = 8'b111_000_1_1;

    typedef struct {
        string      name;
        logic       rst;
        logic       memRead;
        logic [4:0] rtEx;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mulDiv;
        logic       isDiv;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mLuse = 0, mHold = 0, mFlush = 0;
    vec_t sb[$];
    vec_t tblA[$];
    vec_t tblB[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if hz ();

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] statLuse, statHold, statFlush;
`endif

    hazard_stall_ctrl #(
        .MUL_LAT(3),
        .DIV_LAT(8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz.slave)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .Stat_LoadUse_o    (statLuse),
        .Stat_MulDivHold_o (statHold),
        .Stat_Flush_o      (statFlush)
`endif
    );

    function automatic vec_t mk(input string name, input logic r, input logic mr,
                                input logic [4:0] rte, input logic [4:0] rsv,
                                input logic [4:0] rtv, input logic md, input logic dv,
                                input logic b, input logic [7:0] e);
        vec_t v;
        v.name = name; v.rst = r; v.memRead = mr; v.rtEx = rte; v.rs = rsv; v.rt = rtv;
        v.mulDiv = md; v.isDiv = dv; v.br = b; v.exp = e;
        return v;
    endfunction

    // Pops the oldest expectation and compares it to what the DUT drives now.
    task automatic checkOut();
        vec_t       e;
        logic [7:0] got;
        e   = sb.pop_front();
        got = {hz.PC_Write_o, hz.IF_ID_Write_o, hz.ID_EX_Write_o, hz.IF_ID_Flush_o,
               hz.ID_EX_Flush_o, hz.EX_MEM_Flush_o, hz.MulDiv_Busy_o, hz.MulDiv_Done_o};
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (pcW ifW exW ifF exF memF busy done)",
                     e.name, got, e.exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst                   = v.rst;
        hz.ID_EX_MemRead_i    = v.memRead;
        hz.ID_EX_RtAddr_i     = v.rtEx;
        hz.IF_ID_RsAddr_i     = v.rs;
        hz.IF_ID_RtAddr_i     = v.rt;
        hz.ID_EX_MulDiv_i     = v.mulDiv;
        hz.ID_EX_IsDiv_i      = v.isDiv;
        hz.EX_BranchTaken_i   = v.br;
        sb.push_back(v);
        if (v.rst) begin
            mLuse = 0; mHold = 0; mFlush = 0;
        end else begin
            if (v.exp == Luse) mLuse++;
            if (v.exp[2])      mHold++;
            if (v.exp == Br)   mFlush++;
        end
        @(negedge clk);
        checkOut();
    endtask

    task automatic md(input string name, input logic dv, input logic [7:0] e);
        step(mk(name, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, dv, 1'b0, e));
    endtask

    task automatic cmpStat(input string name, input logic [31:0] got, input int unsigned e);
        checks++;
        if (got !== 32'(e)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, e);
        end
    endtask

    initial begin
        hz.ID_EX_MemRead_i  = 1'b0;
        hz.ID_EX_RtAddr_i   = '0;
        hz.IF_ID_RsAddr_i   = '0;
        hz.IF_ID_RtAddr_i   = '0;
        hz.ID_EX_MulDiv_i   = 1'b0;
        hz.ID_EX_IsDiv_i    = 1'b0;
        hz.EX_BranchTaken_i = 1'b0;

        // Load-use and branch scenarios.
        tblA.push_back(mk("reset_forced", 1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1, Norm));
        tblA.push_back(mk("luse_rs",      0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, Luse));
        tblA.push_back(mk("luse_cleared", 0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, Norm));
        tblA.push_back(mk("luse_r0",      0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));
        tblA.push_back(mk("br_over_luse", 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, Br));
        tblA.push_back(mk("after_br",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));
        // Extra patterns run after the reset sequence.
        tblB.push_back(mk("luse_rt",      0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, Luse));
        tblB.push_back(mk("no_memread",   0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 0, Norm));
        tblB.push_back(mk("no_match",     0, 1, 5'd9, 5'd8, 5'd10, 0, 0, 0, Norm));
        tblB.push_back(mk("br_alone",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, Br));
        tblB.push_back(mk("luse_both",    0, 1, 5'd31, 5'd31, 5'd31, 0, 0, 0, Luse));

        for (int i = 0; i < tblA.size(); i++) step(tblA[i]);

        md("mul_h1", 1'b0, Hold0);
        md("mul_h2", 1'b0, HoldB);
        md("mul_done", 1'b0, DoneB);
        step(mk("mul_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));

        md("div_h1", 1'b1, Hold0);
        for (int i = 2; i <= 7; i++) md($sformatf("div_h%0d", i), 1'b1, HoldB);
        md("div_done", 1'b1, DoneB);
        md("b2b_mul_h1", 1'b0, Hold0);
        md("b2b_mul_h2", 1'b0, HoldB);
        md("b2b_mul_done", 1'b0, DoneB);
        step(mk("b2b_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));

`ifdef HAZARD_STALL_STATS_EN
        cmpStat("stat_luse", statLuse, 1);
        cmpStat("stat_hold", statHold, 11);
        cmpStat("stat_flush", statFlush, 1);
`endif

        // Reset lands on the third hold cycle of a DIV.
        md("rdiv_h1", 1'b1, Hold0);
        md("rdiv_h2", 1'b1, HoldB);
        step(mk("rdiv_reset", 1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, Norm));
        step(mk("rdiv_release", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));
        step(mk("rdiv_no_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));

        for (int i = 0; i < tblB.size(); i++) step(tblB[i]);

`ifdef HAZARD_STALL_STATS_EN
        step(mk("stat_settle", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, Norm));
        cmpStat("stat_luse_end", statLuse, mLuse);
        cmpStat("stat_hold_end", statHold, mHold);
        cmpStat("stat_flush_end", statFlush, mFlush);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
